// File: rtl/mem_copy_engine_pkg.sv
// Shared widths and FSM encodings for the memory copy/fill engine.
`timescale 1ns/1ps
package mem_copy_engine_pkg;

    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    localparam logic [1:0] MC_IDLE   = 2'd0;
    localparam logic [1:0] MC_READ   = 2'd1;
    localparam logic [1:0] MC_WRITE  = 2'd2;
    localparam logic [1:0] MC_FINISH = 2'd3;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port memory bus: the engine drives address/write side, memory returns read data.
`timescale 1ns/1ps
interface mem_copy_engine_if
    import mem_copy_engine_pkg::*;
#(
    parameter int AW = ISIZE,
    parameter int DW = DSIZE
);
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / constant fill engine that owns the shared memory port while busy.
`timescale 1ns/1ps
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int AW = ISIZE,
    parameter int DW = DSIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 fill_en,
    input  logic [AW-1:0]        src_addr,
    input  logic [AW-1:0]        dst_addr,
    input  logic [AW-1:0]        len,
    input  logic [DW-1:0]        fill_data,
    input  logic                 abort,
    mem_copy_engine_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        count
);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [AW-1:0] count_q, count_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] fdata_q, fdata_d;
    logic          fill_q, fill_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        count_d = count_q;
        data_d  = data_q;
        fdata_d = fdata_q;
        fill_d  = fill_q;
        case (state_q)
            MC_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    fill_d  = fill_en;
                    fdata_d = fill_data;
                    count_d = '0;
                    if (len == '0)
                        state_d = MC_FINISH;
                    else if (fill_en)
                        state_d = MC_WRITE;
                    else
                        state_d = MC_READ;
                end
            end
            MC_READ: begin
                data_d  = mem.mem_rdata;
                state_d = MC_WRITE;
            end
            MC_WRITE: begin
                // Address arithmetic wraps modulo 2^AW by construction.
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(1);
                count_d = count_q + AW'(1);
                rem_d   = rem_q - AW'(1);
                if (rem_q == AW'(1) || abort)
                    state_d = MC_FINISH;
                else if (fill_q)
                    state_d = MC_WRITE;
                else
                    state_d = MC_READ;
            end
            MC_FINISH: state_d = MC_IDLE;
            default:   state_d = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            fdata_q <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            data_q  <= data_d;
            fdata_q <= fdata_d;
            fill_q  <= fill_d;
        end
    end

    // The memory reloads while rst is high, so a write must never be issued then.
    assign mem.mem_wen   = (state_q == MC_WRITE) && !rst;
    assign mem.mem_addr  = (state_q == MC_READ)  ? src_q :
                           (state_q == MC_WRITE) ? dst_q : '0;
    assign mem.mem_wdata = (state_q == MC_WRITE) ? (fill_q ? fdata_q : data_q) : '0;

    assign busy  = (state_q != MC_IDLE);
    assign done  = (state_q == MC_FINISH);
    assign count = count_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench: expected writes are queued at launch and matched against observed memory writes.
`timescale 1ns/1ps
module tb_mem_copy_engine;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          fill_en = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] fill_data = '0;
    logic          abort = 1'b0;
    logic          busy, done;
    logic [AW-1:0] count;

    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    bit [DW-1:0] mem    [0:(1<<AW)-1];
    bit [DW-1:0] shadow [0:(1<<AW)-1];

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail = 0;
    int  n_spurious = 0;
    int  first_wen_c, last_wen_c;

    mem_copy_engine_if #(.AW(AW), .DW(DW)) mem_if ();

    mem_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fill_en   (fill_en),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .abort     (abort),
        .mem       (mem_if),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, synchronous write, plus a bench load port.
    assign mem_if.mem_rdata = mem[mem_if.mem_addr];
    always @(posedge clk) begin
        if (mem_if.mem_wen)
            mem[mem_if.mem_addr] <= mem_if.mem_wdata;
        else if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_if.mem_wen) begin
            if (exp_q.size() == 0) begin
                n_spurious++;
                $display("unexpected write addr=%0h data=%0h", mem_if.mem_addr, mem_if.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wr_addr", 32'(mem_if.mem_addr), 32'(mon_e.addr));
                check_val("wr_data", 32'(mem_if.mem_wdata), 32'(mon_e.data));
                $display("write addr=%0h data=%0h", mem_if.mem_addr, mem_if.mem_wdata);
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        shadow[a] = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic push_expected(input bit fill, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [DW-1:0] fd, input int words);
        wr_t e;
        for (int i = 0; i < words; i++) begin
            e.addr = dst + AW'(i);
            e.data = fill ? fd : shadow[src + AW'(i)];
            shadow[e.addr] = e.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_xfer(input string name, input bit fill, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input logic [AW-1:0] n,
                           input logic [DW-1:0] fd, input int abort_wr, input bit abort_at_start,
                           input bit poke, input int exp_done, input int exp_words);
        int wr = 0, ndone = 0, done_c = -1;
        first_wen_c = -1; last_wen_c = -1;
        push_expected(fill, src, dst, fd, exp_words);
        @(negedge clk);
        fill_en = fill; src_addr = src; dst_addr = dst; len = n; fill_data = fd;
        start = 1'b1; abort = abort_at_start;
        @(posedge clk);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (poke && c == 2) begin
                start = 1'b1; fill_en = 1'b1; dst_addr = 16'h0400; len = 16'd1; fill_data = 16'hDEAD;
            end
            if (poke && c == 3) start = 1'b0;
            if (mem_if.mem_wen) begin
                wr++;
                if (first_wen_c < 0) first_wen_c = c;
                last_wen_c = c;
            end
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (abort_wr > 0 && mem_if.mem_wen && wr == abort_wr) abort = 1'b1;
            else abort = 1'b0;
            if (done_c >= 0 && c > done_c) break;
        end
        $display("%s: done_cycle=%0d writes=%0d count=%0d", name, done_c, wr, count);
        check_val({name, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check_val({name, "_done_pulses"}, 32'(ndone), 32'd1);
        check_val({name, "_wen_cycles"}, 32'(wr), 32'(exp_words));
        check_val({name, "_count"}, 32'(count), 32'(exp_words));
        check_val({name, "_idle_busy"}, 32'(busy), 32'd0);
        check_val({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [DW-1:0] pat [0:3];

    initial begin
        pat[0] = 16'h00A1; pat[1] = 16'h00B2; pat[2] = 16'h00C3; pat[3] = 16'h00D4;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wen",   32'(mem_if.mem_wen),   32'd0);
        check_val("rst_addr",  32'(mem_if.mem_addr),  32'd0);
        check_val("rst_wdata", 32'(mem_if.mem_wdata), 32'd0);
        check_val("rst_busy",  32'(busy),  32'd0);
        check_val("rst_done",  32'(done),  32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) preload(16'h0010 + AW'(i), pat[i]);

        do_xfer("copy4", 1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0000, 0, 1'b0, 1'b0, 9, 4);
        for (int i = 0; i < 4; i++) begin
            check_val("copy4_dst", 32'(mem[16'h0100 + AW'(i)]), 32'(pat[i]));
            check_val("copy4_src", 32'(mem[16'h0010 + AW'(i)]), 32'(pat[i]));
        end

        do_xfer("fill3", 1'b1, 16'h0000, 16'h0200, 16'd3, 16'h5A5A, 0, 1'b0, 1'b0, 4, 3);
        check_val("fill3_wen_first", 32'(first_wen_c), 32'd1);
        check_val("fill3_wen_span", 32'(last_wen_c - first_wen_c + 1), 32'd3);
        for (int i = 0; i < 3; i++)
            check_val("fill3_dst", 32'(mem[16'h0200 + AW'(i)]), 32'h5A5A);
        check_val("fill3_past_end", 32'(mem[16'h0203]), 32'd0);

        do_xfer("len0", 1'b0, 16'h0010, 16'h0500, 16'd0, 16'h0000, 0, 1'b0, 1'b0, 1, 0);
        check_val("len0_dst", 32'(mem[16'h0500]), 32'd0);

        do_xfer("wrap", 1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1234, 0, 1'b1, 1'b0, 5, 4);
        check_val("wrap_fffe", 32'(mem[16'hFFFE]), 32'h1234);
        check_val("wrap_ffff", 32'(mem[16'hFFFF]), 32'h1234);
        check_val("wrap_0000", 32'(mem[16'h0000]), 32'h1234);
        check_val("wrap_0001", 32'(mem[16'h0001]), 32'h1234);

        for (int i = 0; i < 8; i++) preload(16'h0020 + AW'(i), 16'h1000 + DW'(i));
        do_xfer("abort", 1'b0, 16'h0020, 16'h0600, 16'd8, 16'h0000, 3, 1'b0, 1'b0, 7, 3);
        for (int i = 0; i < 3; i++)
            check_val("abort_dst", 32'(mem[16'h0600 + AW'(i)]), 32'h1000 + 32'(i));
        for (int i = 3; i < 8; i++)
            check_val("abort_untouched", 32'(mem[16'h0600 + AW'(i)]), 32'd0);

        // Reset lands in the WRITE cycle of word 2: only word 1 may reach memory.
        push_expected(1'b0, 16'h0010, 16'h0300, 16'h0000, 1);
        @(negedge clk);
        fill_en = 1'b0; src_addr = 16'h0010; dst_addr = 16'h0300; len = 16'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_val("rstmid_wen_gate", 32'(mem_if.mem_wen), 32'd0);
        @(posedge clk);
        #1;
        check_val("rstmid_busy",  32'(busy),  32'd0);
        check_val("rstmid_count", 32'(count), 32'd0);
        check_val("rstmid_wen",   32'(mem_if.mem_wen), 32'd0);
        check_val("rstmid_done",  32'(done),  32'd0);
        rst = 1'b0;
        check_val("rstmid_word1", 32'(mem[16'h0300]), 32'(pat[0]));
        check_val("rstmid_word2", 32'(mem[16'h0301]), 32'd0);
        check_val("rstmid_sb_empty", 32'(exp_q.size()), 32'd0);

        do_xfer("copy_poke", 1'b0, 16'h0010, 16'h0700, 16'd4, 16'h0000, 0, 1'b0, 1'b1, 9, 4);
        for (int i = 0; i < 4; i++)
            check_val("copy_poke_dst", 32'(mem[16'h0700 + AW'(i)]), 32'(pat[i]));
        check_val("poke_ignored", 32'(mem[16'h0400]), 32'd0);

        repeat (4) @(negedge clk);
        check_val("spurious_writes", 32'(n_spurious), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
